// File: rtl/riscv_m_muldiv_unit.sv
// -----------------------------------------------------------------------------
// riscv_m_muldiv_unit
//
// Multi-cycle integer multiply/divide unit for the RISC-V M extension
// (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the
// combinational ALU in the execute stage.
//
// Handshake rules (both ports):
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. The request side is ready only in IDLE. The response side raises
//   resp_valid_o in DONE and holds out_o/tag_o stable until resp_ready_i is
//   seen. valid never depends on ready on the same port.
//
// Ports:
//   clock_i       system clock
//   resetn_i      asynchronous active-low reset
//   flush_i       abandons any in-flight operation (wins over a new request)
//   req_valid_i   request valid
//   req_ready_o   unit can accept a request (IDLE only)
//   func3_i       0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   in0_i/in1_i   rs1/rs2 operand values
//   tag_i         destination register tag, passed through to tag_o
//   resp_valid_o  result valid
//   resp_ready_i  consumer accepts result
//   out_o/tag_o   result and its tag
//   busy_o        high in any state other than IDLE
//   dbg_state_o   current FSM state (0 IDLE, 1 BUSY, 2 FIX, 3 DONE)
//
// Optional build macro:
//   RISCV_M_FAST_MUL_EN  multiplies use a single-cycle combinational
//                        multiplier and go straight to DONE; divides keep
//                        the iterative path. When undefined no multiplier
//                        is inferred.
// -----------------------------------------------------------------------------
module riscv_m_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock_i,
    input  logic             resetn_i,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       func3_i,
    input  logic [XLEN-1:0]  in0_i,
    input  logic [XLEN-1:0]  in1_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [XLEN-1:0]  out_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [2:0] F_MULH   = 3'd1;
    localparam logic [2:0] F_MULHSU = 3'd2;
    localparam logic [2:0] F_DIV    = 3'd4;
    localparam logic [2:0] F_REM    = 3'd6;

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          func3_q, func3_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic                neg_q, neg_d;     // result needs two's-complement negation
    logic [XLEN-1:0]     opa_q, opa_d;     // multiplicand (mul) or divisor (div) magnitude
    logic [2*XLEN-1:0]   work_q, work_d;   // {hi, lo}: product, or {remainder, quotient}
    logic [XLEN-1:0]     out_q, out_d;

    // ---------------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------------
    logic            accept;
    logic            a_signed, b_signed;
    logic            s_a, s_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            is_div;
    logic            div_by_zero, div_ovf;

    assign is_div   = func3_i[2];
    assign a_signed = (func3_i == F_MULH) || (func3_i == F_MULHSU) ||
                      (func3_i == F_DIV)  || (func3_i == F_REM);
    assign b_signed = (func3_i == F_MULH) || (func3_i == F_DIV) || (func3_i == F_REM);
    assign s_a      = a_signed & in0_i[XLEN-1];
    assign s_b      = b_signed & in1_i[XLEN-1];
    assign mag_a    = s_a ? (~in0_i + 1'b1) : in0_i;
    assign mag_b    = s_b ? (~in1_i + 1'b1) : in1_i;

    assign div_by_zero = is_div && (in1_i == '0);
    // Only the signed ops (DIV, REM) have func3[0] clear.
    assign div_ovf     = is_div && !func3_i[0] && (in0_i == MOST_NEG) && (in1_i == '1);

    // A flush in the same cycle drops the request.
    assign accept = req_valid_i && (state_q == S_IDLE) && !flush_i;

    // ---------------------------------------------------------------------
    // Iteration datapaths
    // ---------------------------------------------------------------------
    // Shift-add multiply: conditionally add the multiplicand into the high
    // half, then shift the whole product right; the multiplier drains out of
    // the low half as product bits fill in from the top.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;

    assign mul_sum  = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, opa_q} : '0);
    assign mul_next = {mul_sum, work_q[XLEN-1:1]};

    // Restoring divide: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. The partial remainder is
    // always below the divisor, so after a successful subtract it fits in
    // XLEN bits and the modular difference is exact.
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] div_next;

    assign div_shift = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, opa_q});
    assign div_diff  = div_shift[XLEN-1:0] - opa_q;
    assign div_next  = div_ge ? {div_diff, work_q[XLEN-2:0], 1'b1}
                              : {div_shift[XLEN-1:0], work_q[XLEN-2:0], 1'b0};

    // ---------------------------------------------------------------------
    // Sign fix-up. Negating the full double-width value gives the right
    // low half as well, so the quotient reuses neg_work; the remainder lives
    // in the high half and is negated on its own.
    // ---------------------------------------------------------------------
    logic [2*XLEN-1:0] neg_work;
    logic [XLEN-1:0]   rem_fix;

    assign neg_work = neg_q ? (~work_q + 1'b1) : work_q;
    assign rem_fix  = neg_q ? (~work_q[2*XLEN-1:XLEN] + 1'b1) : work_q[2*XLEN-1:XLEN];

`ifdef RISCV_M_FAST_MUL_EN
    // Single-cycle multiply on sign/zero-extended operands; the low 2*XLEN
    // bits of the extended product are the exact signed/unsigned product.
    logic [2*XLEN-1:0] ext_a, ext_b, fast_prod;
    logic [XLEN-1:0]   fast_res;

    assign ext_a     = {{XLEN{a_signed & in0_i[XLEN-1]}}, in0_i};
    assign ext_b     = {{XLEN{b_signed & in1_i[XLEN-1]}}, in1_i};
    assign fast_prod = ext_a * ext_b;
    assign fast_res  = (func3_i[1:0] == 2'b00) ? fast_prod[XLEN-1:0]
                                               : fast_prod[2*XLEN-1:XLEN];
`endif

    // ---------------------------------------------------------------------
    // Next-state / datapath control
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        func3_d = func3_q;
        tag_d   = tag_q;
        neg_d   = neg_q;
        opa_d   = opa_q;
        work_d  = work_q;
        out_d   = out_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    func3_d = func3_i;
                    tag_d   = tag_i;
                    // Remainder takes the dividend's sign; everything else
                    // takes the XOR of the operand signs.
                    neg_d   = (func3_i[2] && func3_i[1]) ? s_a : (s_a ^ s_b);
                    if (div_by_zero) begin
                        out_d   = func3_i[1] ? in0_i : '1;
                        state_d = S_DONE;
                    end else if (div_ovf) begin
                        out_d   = func3_i[1] ? '0 : MOST_NEG;
                        state_d = S_DONE;
`ifdef RISCV_M_FAST_MUL_EN
                    end else if (!is_div) begin
                        out_d   = fast_res;
                        state_d = S_DONE;
`endif
                    end else begin
                        opa_d   = is_div ? mag_b : mag_a;
                        work_d  = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                        cnt_d   = CNT_W'(XLEN);
                        state_d = S_BUSY;
                    end
                end
            end

            S_BUSY: begin
                work_d = func3_q[2] ? div_next : mul_next;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_d == '0) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                if (!func3_q[2]) begin
                    out_d = (func3_q[1:0] == 2'b00) ? neg_work[XLEN-1:0]
                                                    : neg_work[2*XLEN-1:XLEN];
                end else if (!func3_q[1]) begin
                    out_d = neg_work[XLEN-1:0];
                end else begin
                    out_d = rem_fix;
                end
                state_d = S_DONE;
            end

            S_DONE: begin
                if (resp_ready_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush abandons whatever is in flight, including a pending result.
        if (flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            func3_q <= '0;
            tag_q   <= '0;
            neg_q   <= 1'b0;
            opa_q   <= '0;
            work_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            func3_q <= func3_d;
            tag_q   <= tag_d;
            neg_q   <= neg_d;
            opa_q   <= opa_d;
            work_q  <= work_d;
            out_q   <= out_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign req_ready_o  = (state_q == S_IDLE);
    assign resp_valid_o = (state_q == S_DONE);
    assign busy_o       = (state_q != S_IDLE);
    assign out_o        = out_q;
    assign tag_o        = tag_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_riscv_m_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_riscv_m_muldiv_unit
//
// Self-checking bench for riscv_m_muldiv_unit (XLEN=32). A reference model
// computes each result with plain 64-bit arithmetic and the response latency
// from the operation class; one compare process checks the outputs every
// cycle against the expected queue.
// -----------------------------------------------------------------------------
module tb_riscv_m_muldiv_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam logic [XLEN-1:0] MIN_V = 32'h8000_0000;

    // ---------------------------------------------------------------------
    // Clock / reset and DUT
    // ---------------------------------------------------------------------
    logic             clock_i = 1'b0;
    logic             resetn_i;
    logic             flush_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [2:0]       func3_i;
    logic [XLEN-1:0]  in0_i, in1_i;
    logic [TAG_W-1:0] tag_i;
    logic             resp_valid_o;
    logic             resp_ready_i;
    logic [XLEN-1:0]  out_o;
    logic [TAG_W-1:0] tag_o;
    logic             busy_o;
    logic [1:0]       dbg_state_o;

    always #5 clock_i = ~clock_i;

    riscv_m_muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clock_i      (clock_i),
        .resetn_i     (resetn_i),
        .flush_i      (flush_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .func3_i      (func3_i),
        .in0_i        (in0_i),
        .in1_i        (in1_i),
        .tag_i        (tag_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .out_o        (out_o),
        .tag_o        (tag_o),
        .busy_o       (busy_o),
        .dbg_state_o  (dbg_state_o)
    );

    // ---------------------------------------------------------------------
    // Check bookkeeping
    // ---------------------------------------------------------------------
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic fail_now(input string name);
        total_cnt++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    function automatic logic [XLEN-1:0] model(input logic [2:0] f, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (f)
            3'd0: begin p = ua * ub;            return p[31:0];  end
            3'd1: begin p = sa * sb;            return p[63:32]; end
            3'd2: begin p = sa * longint'(ub);  return p[63:32]; end
            3'd3: begin p = ua * ub;            return p[63:32]; end
            3'd4: begin
                if (b == '0) return '1;
                if (a == MIN_V && b == '1) return MIN_V;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == '0) return '1;
                p = ua / ub;
                return p[31:0];
            end
            3'd6: begin
                if (b == '0) return a;
                if (a == MIN_V && b == '1) return '0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == '0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
        if (f[2] && b == '0) return 1;
        if (f[2] && !f[0] && a == MIN_V && b == '1) return 1;
`ifdef RISCV_M_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return XLEN + 2;
    endfunction

    // ---------------------------------------------------------------------
    // Scoreboard / compare process (samples on the falling edge)
    // ---------------------------------------------------------------------
    logic [XLEN-1:0]  exp_q[$];
    logic [TAG_W-1:0] exp_tag_q[$];
    int               cyc      = 0;
    int               due_cyc  = 0;
    int               acc_cyc  = 0;
    int               last_lat = 0;
    bit               seen_v   = 0;
    int               resp_cnt = 0;
    logic [XLEN-1:0]  last_out = '0;
    logic [TAG_W-1:0] last_tag = '0;

    always @(negedge clock_i) begin
        cyc = cyc + 1;
        if (!resetn_i) begin
            exp_q.delete();
            exp_tag_q.delete();
        end else if (exp_q.size() != 0) begin
            chk("resp_valid", 64'(resp_valid_o), 64'(cyc >= due_cyc));
            chk("req_ready_busy", 64'(req_ready_o), 64'd0);
            chk("busy_inflight", 64'(busy_o), 64'd1);
            if (resp_valid_o) begin
                chk("out", 64'(out_o), 64'(exp_q[0]));
                chk("tag", 64'(tag_o), 64'(exp_tag_q[0]));
                if (!seen_v) begin
                    seen_v   = 1;
                    last_lat = cyc - acc_cyc;
                end
            end
            if (flush_i) begin
                void'(exp_q.pop_front());
                void'(exp_tag_q.pop_front());
            end else if (resp_valid_o && resp_ready_i) begin
                resp_cnt++;
                last_out = out_o;
                last_tag = tag_o;
                void'(exp_q.pop_front());
                void'(exp_tag_q.pop_front());
            end
        end else begin
            chk("idle_resp_valid", 64'(resp_valid_o), 64'd0);
            chk("idle_req_ready", 64'(req_ready_o), 64'd1);
            chk("idle_busy", 64'(busy_o), 64'd0);
            if (req_valid_i && req_ready_o && !flush_i) begin
                exp_q.push_back(model(func3_i, in0_i, in1_i));
                exp_tag_q.push_back(tag_i);
                acc_cyc = cyc;
                due_cyc = cyc + model_lat(func3_i, in0_i, in1_i);
                seen_v  = 0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Response-ready driver
    // ---------------------------------------------------------------------
    bit hold_rr = 0;

    initial begin
        resp_ready_i = 1'b0;
        forever begin
            @(posedge clock_i);
            #1;
            resp_ready_i = hold_rr ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------------------------------------------------------------
    // Request driver tasks
    // ---------------------------------------------------------------------
    task automatic send(input logic [2:0] f, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [TAG_W-1:0] t);
        bit ok;
        @(posedge clock_i);
        #1;
        req_valid_i = 1'b1;
        func3_i     = f;
        in0_i       = a;
        in1_i       = b;
        tag_i       = t;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock_i);
            if (req_ready_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now("send_wait_ready");
        @(posedge clock_i);
        #1;
        req_valid_i = 1'b0;
        in0_i       = $urandom;
        in1_i       = $urandom;
        tag_i       = TAG_W'($urandom);
    endtask

    task automatic wait_resp(input int n);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock_i);
            #1;
            if (resp_cnt != n) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now("wait_resp");
    endtask

    task automatic do_op(input string name, input logic [2:0] f, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [TAG_W-1:0] t,
                         input logic [XLEN-1:0] lit, input int lat);
        int n;
        n = resp_cnt;
        send(f, a, b, t);
        wait_resp(n);
        chk({name, "_out"}, 64'(last_out), 64'(lit));
        chk({name, "_tag"}, 64'(last_tag), 64'(t));
        chk({name, "_lat"}, 64'(last_lat), 64'(lat));
    endtask

    function automatic logic [XLEN-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return MIN_V;
            2:       return '1;
            3:       return XLEN'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // ---------------------------------------------------------------------
    // Main sequence
    // ---------------------------------------------------------------------
    int              mul_lat;
    int              n0;
    logic [XLEN-1:0] held_out;
    logic [TAG_W-1:0] held_tag;

    initial begin
`ifdef RISCV_M_FAST_MUL_EN
        mul_lat = 1;
`else
        mul_lat = XLEN + 2;
`endif
        resetn_i    = 1'b1;
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        func3_i     = '0;
        in0_i       = '0;
        in1_i       = '0;
        tag_i       = '0;
        #2 resetn_i = 1'b0;
        #2;
        chk("rst_req_ready", 64'(req_ready_o), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_out", 64'(out_o), 64'd0);
        chk("rst_tag", 64'(tag_o), 64'd0);
        repeat (2) @(posedge clock_i);
        #2 resetn_i = 1'b1;

        // Pin the model against hand-computed values.
        chk("model_mulh", 64'(model(3'd1, 32'h8000_0000, 32'h8000_0000)), 64'h4000_0000);
        chk("model_mulhsu", 64'(model(3'd2, '1, '1)), 64'hFFFF_FFFF);
        chk("model_mulhu", 64'(model(3'd3, '1, '1)), 64'hFFFF_FFFE);
        chk("model_div", 64'(model(3'd4, 32'hFFFF_FFF9, 32'd2)), 64'hFFFF_FFFD);
        chk("model_rem", 64'(model(3'd6, 32'hFFFF_FFF9, 32'd2)), 64'hFFFF_FFFF);

        // Directed operations with literal results and latencies.
        do_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd3,  32'h4000_0000, mul_lat);
        do_op("mulhsu", 3'd2, '1, '1, 5'd4,  32'hFFFF_FFFF, mul_lat);
        do_op("mulhu",  3'd3, '1, '1, 5'd5,  32'hFFFF_FFFE, mul_lat);
        do_op("mul",    3'd0, '1, '1, 5'd6,  32'h0000_0001, mul_lat);
        do_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, XLEN + 2);
        do_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, XLEN + 2);
        do_op("divu0",  3'd5, 32'd7, 32'd0, 5'd9,  32'hFFFF_FFFF, 1);
        do_op("remu0",  3'd7, 32'd7, 32'd0, 5'd10, 32'h0000_0007, 1);
        do_op("divovf", 3'd4, 32'h8000_0000, '1, 5'd11, 32'h8000_0000, 1);
        do_op("removf", 3'd6, 32'h8000_0000, '1, 5'd12, 32'h0000_0000, 1);

        // Backpressure: hold resp_ready low for 5 cycles after valid.
        hold_rr = 1;
        send(3'd5, 32'd1000, 32'd7, 5'd21);
        begin : wait_valid
            bit ok;
            ok = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clock_i);
                #1;
                if (resp_valid_o) begin
                    ok = 1;
                    break;
                end
            end
            if (!ok) fail_now("bp_wait_valid");
        end
        held_out = out_o;
        held_tag = tag_o;
        chk("bp_out_value", 64'(held_out), 64'd142);
        repeat (5) @(negedge clock_i);
        #1;
        chk("bp_out_stable", 64'(out_o), 64'(held_out));
        chk("bp_tag_stable", 64'(tag_o), 64'd21);
        chk("bp_req_ready", 64'(req_ready_o), 64'd0);
        chk("bp_valid_held", 64'(resp_valid_o), 64'd1);
        hold_rr = 0;
        // Back-to-back request queued right behind the held response.
        n0 = resp_cnt;
        send(3'd7, 32'd1000, 32'd7, 5'd22);
        wait_resp(n0 + 1);
        chk("b2b_out", 64'(last_out), 64'd6);
        chk("b2b_tag", 64'(last_tag), 64'd22);

        // Flush at accept+10 during a DIVU: no response, back to IDLE.
        n0 = resp_cnt;
        send(3'd5, 32'd12345, 32'd17, 5'd23);
        repeat (9) @(posedge clock_i);
        #1 flush_i = 1'b1;
        @(posedge clock_i);
        #1 flush_i = 1'b0;
        chk("flush_idle_busy", 64'(busy_o), 64'd0);
        chk("flush_idle_valid", 64'(resp_valid_o), 64'd0);
        repeat (50) @(posedge clock_i);
        chk("flush_no_resp", 64'(resp_cnt), 64'(n0));

        // Flush together with a request in IDLE: request dropped.
        @(posedge clock_i);
        #1;
        req_valid_i = 1'b1;
        flush_i     = 1'b1;
        func3_i     = 3'd0;
        in0_i       = 32'd3;
        in1_i       = 32'd4;
        @(posedge clock_i);
        #1;
        req_valid_i = 1'b0;
        flush_i     = 1'b0;
        chk("flush_req_dropped", 64'(busy_o), 64'd0);

        // Asynchronous reset mid-BUSY.
        n0 = resp_cnt;
        send(3'd5, 32'hDEAD_BEEF, 32'd3, 5'd24);
        repeat (5) @(posedge clock_i);
        #3 resetn_i = 1'b0;
        #1;
        chk("mid_rst_req_ready", 64'(req_ready_o), 64'd1);
        chk("mid_rst_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        chk("mid_rst_out", 64'(out_o), 64'd0);
        chk("mid_rst_tag", 64'(tag_o), 64'd0);
        @(posedge clock_i);
        #2 resetn_i = 1'b1;
        repeat (50) @(posedge clock_i);
        chk("mid_rst_no_resp", 64'(resp_cnt), 64'(n0));

        // Randomized operations; the compare process checks every cycle.
        for (int k = 0; k < 120; k++) begin
            n0 = resp_cnt;
            send(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                 TAG_W'($urandom));
            wait_resp(n0);
        end

        repeat (5) @(posedge clock_i);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/riscv_m_muldiv_unit.md
Name: riscv_m_muldiv_unit

Overview:
Parametrised multi-cycle integer multiply/divide unit implementing the RISC-V M extension (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the combinational RV32I ALU in the execute stage. It takes ENCODING_ARITH_REG operations with func7 = 0000001. Operands are accepted through a valid/ready request port, and the result is returned on a valid/ready response port tagged with the destination register.

Parameters:
XLEN, 32, operand/result width; supported values 32 and 64.
TAG_W, 5, width of the passthrough destination tag.

Ports:
clock_i  input  1  system clock
resetn_i  input  1  asynchronous active-low reset
flush_i  input  1  pipeline flush; abandons any in-flight operation
req_valid_i  input  1  request valid
req_ready_o  output  1  unit can accept a request (IDLE only)
func3_i  input  3  M-extension func3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
in0_i  input  XLEN  rs1 value
in1_i  input  XLEN  rs2 value
tag_i  input  TAG_W  destination register tag
resp_valid_o  output  1  result valid
resp_ready_i  input  1  consumer accepts result
out_o  output  XLEN  result
tag_o  output  TAG_W  tag of the result
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clock_i. Reset resetn_i is asynchronous, active-low.
- Reset values: state=IDLE, req_ready_o=1, resp_valid_o=0, busy_o=0, out_o=0, tag_o=0, iteration counter=0.
- State machine: IDLE, BUSY, FIX, DONE.
- Accept: a request is accepted on an edge where req_valid_i and req_ready_o are both high. At that edge the unit latches func3, tag, operand magnitudes and result-sign flags.
  - Signedness per op: MULH uses signed×signed; MULHSU uses signed×unsigned; DIV/REM are signed; the rest are unsigned.
- IDLE -> BUSY on a normal accept; the counter is loaded with XLEN.
- BUSY: one iteration per cycle; the counter decrements.
  - Multiply: shift-add into a 2×XLEN product.
  - Divide: restoring shift-subtract into quotient and remainder.
  - BUSY -> FIX when the counter reaches 0.
- FIX (1 cycle):
  - Apply two's-complement negation where required. Product sign = sA^sB. Quotient sign = sA^sB. Remainder sign = dividend sign.
  - Select the output: MUL = low XLEN bits; MULH/MULHSU/MULHU = high XLEN bits; DIV/DIVU = quotient; REM/REMU = remainder.
  - FIX -> DONE.
- DONE:
  - resp_valid_o=1; out_o and tag_o are held stable until resp_ready_i.
  - DONE -> IDLE on the edge where resp_valid_o and resp_ready_i are both high.
  - req_ready_o stays 0 in DONE. A new request can be accepted at the earliest on the cycle after the response handshake.
- Normal latency: resp_valid_o rises XLEN+2 edges after the accepting edge.
- Special cases bypass BUSY: the accept edge goes straight to DONE, so resp_valid_o rises 1 edge after accept.
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give in0_i.
  - Signed overflow (DIV/REM with in0=most-negative, in1=all-ones): DIV gives the most-negative value; REM gives 0.
- Flush:
  - flush_i high at any edge forces IDLE, clears resp_valid_o and discards the result.
  - If flush_i and req_valid_i are high together in IDLE, the request is dropped (flush wins).
- Reset mid-operation: immediate return to reset values; no response is produced.
- All arithmetic is modulo 2^XLEN except the internal 2×XLEN product. No exceptions are raised.

Optional Feature:
Macro: RISCV_M_FAST_MUL_EN
- Defined:
  - The four multiply ops use a single-cycle 2×XLEN combinational multiplier on the signed/unsigned extended operands.
  - Accept goes directly to DONE; resp_valid_o rises 1 edge after accept.
  - Divides are unchanged.
- Undefined: multiplies use the iterative BUSY/FIX path with XLEN+2 latency. No multiplier is inferred.

Test Plan:
- MULH, in0=0x80000000, in1=0x80000000 -> out_o=0x40000000, tag echoed; resp_valid_o at accept+34 (accept+1 with RISCV_M_FAST_MUL_EN).
- MULHSU, in0=0xFFFFFFFF, in1=0xFFFFFFFF -> out_o=0xFFFFFFFF. MULHU with the same operands -> 0xFFFFFFFE. MUL with the same operands -> 0x00000001.
- DIV, in0=0xFFFFFFF9 (−7), in1=2 -> out_o=0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. Both respond at accept+34.
- Special cases, each at accept+1:
  - DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 0x00000007.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
- Backpressure: hold resp_ready_i=0 for 5 cycles after resp_valid_o -> out_o/tag_o stable, req_ready_o=0. Release -> IDLE the next edge, and a back-to-back request is accepted.
- flush_i pulsed at accept+10 during a DIVU -> no resp_valid_o, IDLE next cycle. Assert resetn_i=0 mid-BUSY -> all outputs return to reset values asynchronously.
